// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the two-requester data-memory arbiter:
// bus widths, refused port addresses and FSM state encoding.
package data_memory_arbiter_pkg;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 8;

   localparam logic [ADDR_W-1:0] INPUT_PORT_ADDR  = 10'h3FE;
   localparam logic [ADDR_W-1:0] OUTPUT_PORT_ADDR = 10'h3FF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ADDR   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Port addresses are reserved for the CPU; the DMA is refused there.
   function automatic logic is_port_addr(input logic [ADDR_W-1:0] addr);
      return (addr == INPUT_PORT_ADDR) || (addr == OUTPUT_PORT_ADDR);
   endfunction

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the
// requester that was not granted last (last = index of previous grant).
module rr_arbiter_2
   import data_memory_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   // One-hot grant decode from the request pair and the previous winner.
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// Arbitrates CPU (0) and DMA (1) access to the memory manager and sequences
// each access through IDLE -> ADDR -> ACCESS -> DONE with registered strobes.
module data_memory_arbiter #(
   parameter int ADDR_W = data_memory_arbiter_pkg::ADDR_W,
   parameter int DATA_W = data_memory_arbiter_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_req_0,
   input  logic              in_req_1,
   input  logic              in_we_0,
   input  logic              in_we_1,
   input  logic [ADDR_W-1:0] in_addr_0,
   input  logic [ADDR_W-1:0] in_addr_1,
   input  logic [DATA_W-1:0] in_wdata_0,
   input  logic [DATA_W-1:0] in_wdata_1,
   output logic              out_ack_0,
   output logic              out_ack_1,
   output logic              out_err,
   output logic [DATA_W-1:0] out_rdata,
   output logic              out_busy,
   output logic              out_mem_addr_write_en,
   output logic              out_mem_read_en,
   output logic              out_mem_write_en,
   output logic [ADDR_W-1:0] out_mem_addr,
   output logic [DATA_W-1:0] out_mem_data,
   input  logic [DATA_W-1:0] in_mem_data
);

   import data_memory_arbiter_pkg::*;

   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_data_q, mem_data_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              ack_0_q, ack_0_d;
   logic              ack_1_q, ack_1_d;
   logic              busy_q, busy_d;
   logic              addr_we_q, addr_we_d;
   logic              rd_en_q, rd_en_d;
   logic              wr_en_q, wr_en_d;
   logic [1:0]        grant_s;

   rr_arbiter_2 u_rr (
      .req   ({in_req_1, in_req_0}),
      .last  (last_q),
      .grant (grant_s)
   );

   // Next-state, request latching and read-data capture.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      owner_d    = owner_q;
      we_d       = we_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      rdata_d    = rdata_q;
      err_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_s != 2'b00) begin
               owner_d    = grant_s[1];
               last_d     = grant_s[1];
               we_d       = grant_s[1] ? in_we_1    : in_we_0;
               mem_addr_d = grant_s[1] ? in_addr_1  : in_addr_0;
               mem_data_d = grant_s[1] ? in_wdata_1 : in_wdata_0;
               // A refused DMA access skips the memory phases entirely.
               if (grant_s[1] && is_port_addr(in_addr_1)) begin
                  state_d = ST_DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = ST_ADDR;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ADDR: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            state_d = ST_DONE;
            if (!we_q) begin
               rdata_d = in_mem_data;
            end else begin
               rdata_d = rdata_q;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output strobes are decoded from the next state so they register in step with it.
   always_comb begin
      addr_we_d = (state_d == ST_ADDR);
      rd_en_d   = (state_d == ST_ACCESS) && !we_d;
      wr_en_d   = (state_d == ST_ACCESS) && we_d;
      ack_0_d   = (state_d == ST_DONE) && !owner_d;
      ack_1_d   = (state_d == ST_DONE) && owner_d;
      busy_d    = (state_d != ST_IDLE);
   end

   // State and output registers; reset favours requester 0 on the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         last_q     <= 1'b1;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         ack_0_q    <= 1'b0;
         ack_1_q    <= 1'b0;
         busy_q     <= 1'b0;
         addr_we_q  <= 1'b0;
         rd_en_q    <= 1'b0;
         wr_en_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         ack_0_q    <= ack_0_d;
         ack_1_q    <= ack_1_d;
         busy_q     <= busy_d;
         addr_we_q  <= addr_we_d;
         rd_en_q    <= rd_en_d;
         wr_en_q    <= wr_en_d;
      end
   end

   assign out_ack_0             = ack_0_q;
   assign out_ack_1             = ack_1_q;
   assign out_err               = err_q;
   assign out_rdata             = rdata_q;
   assign out_busy              = busy_q;
   assign out_mem_addr_write_en = addr_we_q;
   assign out_mem_read_en       = rd_en_q;
   assign out_mem_write_en      = wr_en_q;
   assign out_mem_addr          = mem_addr_q;
   assign out_mem_data          = mem_data_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed scenarios plus a randomized run against a cycle-schedule model
// of the arbiter's transaction timing.
module tb_data_memory_arbiter;

   localparam int AW = 10;
   localparam int DW = 8;
   localparam int N  = 400;

   localparam logic [6:0] B_AWE = 7'b1000000;
   localparam logic [6:0] B_RD  = 7'b0100000;
   localparam logic [6:0] B_WR  = 7'b0010000;
   localparam logic [6:0] B_A0  = 7'b0001000;
   localparam logic [6:0] B_A1  = 7'b0000100;
   localparam logic [6:0] B_ERR = 7'b0000010;
   localparam logic [6:0] B_BSY = 7'b0000001;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_req_0 = 1'b0, in_req_1 = 1'b0;
   logic          in_we_0 = 1'b0, in_we_1 = 1'b0;
   logic [AW-1:0] in_addr_0 = '0, in_addr_1 = '0;
   logic [DW-1:0] in_wdata_0 = '0, in_wdata_1 = '0;
   logic [DW-1:0] in_mem_data = '0;
   logic          out_ack_0, out_ack_1, out_err, out_busy;
   logic          out_mem_addr_write_en, out_mem_read_en, out_mem_write_en;
   logic [DW-1:0] out_rdata, out_mem_data;
   logic [AW-1:0] out_mem_addr;
   logic [6:0]    obs;

   int total = 0;
   int bad   = 0;

   logic [6:0]    exp_v [0:N+7];
   logic          a_chk [0:N+7];
   logic [AW-1:0] a_val [0:N+7];
   logic          d_chk [0:N+7];
   logic [DW-1:0] d_val [0:N+7];

   data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .in_req_0              (in_req_0),
      .in_req_1              (in_req_1),
      .in_we_0               (in_we_0),
      .in_we_1               (in_we_1),
      .in_addr_0             (in_addr_0),
      .in_addr_1             (in_addr_1),
      .in_wdata_0            (in_wdata_0),
      .in_wdata_1            (in_wdata_1),
      .out_ack_0             (out_ack_0),
      .out_ack_1             (out_ack_1),
      .out_err               (out_err),
      .out_rdata             (out_rdata),
      .out_busy              (out_busy),
      .out_mem_addr_write_en (out_mem_addr_write_en),
      .out_mem_read_en       (out_mem_read_en),
      .out_mem_write_en      (out_mem_write_en),
      .out_mem_addr          (out_mem_addr),
      .out_mem_data          (out_mem_data),
      .in_mem_data           (in_mem_data)
   );

   assign obs = {out_mem_addr_write_en, out_mem_read_en, out_mem_write_en,
                 out_ack_0, out_ack_1, out_err, out_busy};

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_req_0 = 1'b0;
      in_req_1 = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      total++;
      if (obs !== 7'b0000000) begin
         bad++; $display("FAIL reset_outs got=%b exp=%b", obs, 7'b0000000);
      end
      total++;
      if (out_rdata !== 8'h00 || out_mem_data !== 8'h00) begin
         bad++; $display("FAIL reset_data got=%h/%h exp=00/00", out_rdata, out_mem_data);
      end
      total++;
      if (out_mem_addr !== 10'h000) begin
         bad++; $display("FAIL reset_addr got=%h exp=000", out_mem_addr);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_write();
      in_req_0 = 1'b1; in_we_0 = 1'b1; in_addr_0 = 10'h00F; in_wdata_0 = 8'h99;
      step();
      total++;
      if (obs !== (B_AWE | B_BSY) || out_mem_addr !== 10'h00F) begin
         bad++; $display("FAIL wr_cyc1 got=%b/%h exp=%b/00f", obs, out_mem_addr, B_AWE | B_BSY);
      end
      step();
      total++;
      if (obs !== (B_WR | B_BSY) || out_mem_data !== 8'h99 || out_mem_addr !== 10'h00F) begin
         bad++; $display("FAIL wr_cyc2 got=%b/%h/%h exp=%b/00f/99", obs, out_mem_addr, out_mem_data, B_WR | B_BSY);
      end
      step();
      total++;
      if (obs !== (B_A0 | B_BSY) || out_rdata !== 8'h00) begin
         bad++; $display("FAIL wr_ack got=%b/%h exp=%b/00", obs, out_rdata, B_A0 | B_BSY);
      end
      in_req_0 = 1'b0;
      step();
      total++;
      if (obs !== 7'b0000000) begin
         bad++; $display("FAIL wr_idle got=%b exp=0000000", obs);
      end
   endtask

   task automatic test_read();
      int rd_cnt;
      rd_cnt = 0;
      in_mem_data = 8'h99;
      in_req_0 = 1'b1; in_we_0 = 1'b0; in_addr_0 = 10'h00F; in_wdata_0 = 8'h55;
      for (int i = 0; i < 3; i++) begin
         step();
         if (out_mem_read_en === 1'b1) rd_cnt++;
      end
      total++;
      if (obs !== (B_A0 | B_BSY) || out_rdata !== 8'h99) begin
         bad++; $display("FAIL rd_ack got=%b/%h exp=%b/99", obs, out_rdata, B_A0 | B_BSY);
      end
      in_req_0 = 1'b0;
      in_mem_data = 8'h00;
      step();
      if (out_mem_read_en === 1'b1) rd_cnt++;
      total++;
      if (rd_cnt !== 1) begin
         bad++; $display("FAIL rd_len got=%0d exp=1", rd_cnt);
      end
      total++;
      if (out_rdata !== 8'h99) begin
         bad++; $display("FAIL rd_hold got=%h exp=99", out_rdata);
      end
   endtask

   task automatic test_round_robin();
      int n_ack, n_grant;
      int ack_ord [3];
      int gnt_ord [3];
      do_reset();
      in_req_0 = 1'b1; in_we_0 = 1'b1; in_addr_0 = 10'h011; in_wdata_0 = 8'h11;
      in_req_1 = 1'b1; in_we_1 = 1'b1; in_addr_1 = 10'h022; in_wdata_1 = 8'h22;
      n_ack = 0;
      n_grant = 0;
      for (int c = 0; c < 30 && n_ack < 3; c++) begin
         step();
         total++;
         if ($countones(obs[6:2]) > 1) begin
            bad++; $display("FAIL rr_overlap cyc=%0d got=%b exp=at most one strobe", c, obs);
         end
         if (out_mem_addr_write_en === 1'b1 && n_grant < 3) begin
            gnt_ord[n_grant] = (out_mem_addr === 10'h022) ? 1 : 0;
            n_grant++;
         end
         if (out_ack_0 === 1'b1) begin ack_ord[n_ack] = 0; n_ack++; end
         if (out_ack_1 === 1'b1 && n_ack < 3) begin ack_ord[n_ack] = 1; n_ack++; end
      end
      total++;
      if (n_ack != 3 || n_grant != 3) begin
         bad++; $display("FAIL rr_timeout got acks=%0d grants=%0d exp=3/3", n_ack, n_grant);
      end else begin
         total++;
         if (ack_ord[0] != 0 || ack_ord[1] != 1 || ack_ord[2] != 0) begin
            bad++; $display("FAIL rr_ack_order got=%0d%0d%0d exp=010", ack_ord[0], ack_ord[1], ack_ord[2]);
         end
         total++;
         if (gnt_ord[0] != 0 || gnt_ord[1] != 1 || gnt_ord[2] != 0) begin
            bad++; $display("FAIL rr_grant_order got=%0d%0d%0d exp=010", gnt_ord[0], gnt_ord[1], gnt_ord[2]);
         end
      end
      in_req_0 = 1'b0;
      in_req_1 = 1'b0;
      step();
      step();
   endtask

   task automatic test_refused();
      logic [DW-1:0] rd_before;
      rd_before = out_rdata;
      in_req_1 = 1'b1; in_we_1 = 1'b1; in_addr_1 = 10'h3FF; in_wdata_1 = 8'hAA;
      step();
      total++;
      if (obs !== (B_A1 | B_ERR | B_BSY)) begin
         bad++; $display("FAIL ref_ack got=%b exp=%b", obs, B_A1 | B_ERR | B_BSY);
      end
      in_req_1 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         total++;
         if (obs !== 7'b0000000 || out_rdata !== rd_before) begin
            bad++; $display("FAIL ref_after cyc=%0d got=%b/%h exp=0000000/%h", i, obs, out_rdata, rd_before);
         end
      end
      in_req_0 = 1'b1; in_we_0 = 1'b1; in_addr_0 = 10'h3FE; in_wdata_0 = 8'h3C;
      step();
      total++;
      if (obs !== (B_AWE | B_BSY) || out_mem_addr !== 10'h3FE) begin
         bad++; $display("FAIL cpu_port_addr got=%b/%h exp=%b/3fe", obs, out_mem_addr, B_AWE | B_BSY);
      end
      step();
      step();
      total++;
      if (obs !== (B_A0 | B_BSY)) begin
         bad++; $display("FAIL cpu_port_ack got=%b exp=%b", obs, B_A0 | B_BSY);
      end
      in_req_0 = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      in_req_0 = 1'b1; in_we_0 = 1'b1; in_addr_0 = 10'h0AA; in_wdata_0 = 8'h77;
      step();
      step();
      total++;
      if (obs !== (B_WR | B_BSY)) begin
         bad++; $display("FAIL rm_access got=%b exp=%b", obs, B_WR | B_BSY);
      end
      #1 rst_n = 1'b0;
      #1;
      total++;
      if (obs !== 7'b0000000) begin
         bad++; $display("FAIL rm_async got=%b exp=0000000", obs);
      end
      in_req_0 = 1'b0;
      step();
      step();
      total++;
      if (obs !== 7'b0000000) begin
         bad++; $display("FAIL rm_no_ack got=%b exp=0000000", obs);
      end
      rst_n = 1'b1;
      in_req_0 = 1'b1; in_we_0 = 1'b0; in_addr_0 = 10'h0B0;
      in_req_1 = 1'b1; in_we_1 = 1'b0; in_addr_1 = 10'h0C0;
      step();
      total++;
      if (obs !== (B_AWE | B_BSY) || out_mem_addr !== 10'h0B0) begin
         bad++; $display("FAIL rm_first_grant got=%b/%h exp=%b/0b0", obs, out_mem_addr, B_AWE | B_BSY);
      end
      step();
      step();
      in_req_0 = 1'b0;
      in_req_1 = 1'b0;
      step();
      step();
   endtask

   task automatic test_busy_ignore();
      in_req_0 = 1'b1; in_we_0 = 1'b0; in_addr_0 = 10'h123;
      step();
      in_req_1 = 1'b1; in_we_1 = 1'b1; in_addr_1 = 10'h321; in_wdata_1 = 8'h5A;
      step();
      total++;
      if (obs !== (B_RD | B_BSY) || out_mem_addr !== 10'h123) begin
         bad++; $display("FAIL bi_access got=%b/%h exp=%b/123", obs, out_mem_addr, B_RD | B_BSY);
      end
      step();
      total++;
      if (obs !== (B_A0 | B_BSY)) begin
         bad++; $display("FAIL bi_ack0 got=%b exp=%b", obs, B_A0 | B_BSY);
      end
      in_req_0 = 1'b0;
      step();
      total++;
      if (obs !== 7'b0000000) begin
         bad++; $display("FAIL bi_idle got=%b exp=0000000", obs);
      end
      step();
      total++;
      if (obs !== (B_AWE | B_BSY) || out_mem_addr !== 10'h321) begin
         bad++; $display("FAIL bi_grant1 got=%b/%h exp=%b/321", obs, out_mem_addr, B_AWE | B_BSY);
      end
      step();
      step();
      total++;
      if (obs !== (B_A1 | B_BSY)) begin
         bad++; $display("FAIL bi_ack1 got=%b exp=%b", obs, B_A1 | B_BSY);
      end
      in_req_1 = 1'b0;
      step();
   endtask

   task automatic test_random();
      logic          r_req [2];
      logic          r_we [2];
      logic [AW-1:0] r_addr [2];
      logic [DW-1:0] r_wdata [2];
      logic          drop [2];
      logic          last_g, g;
      logic [DW-1:0] exp_rd, mdat;
      int            free_at, cap_at;
      do_reset();
      last_g = 1'b1;
      free_at = 0;
      cap_at = -1;
      exp_rd = 8'h00;
      for (int i = 0; i < N + 8; i++) begin
         exp_v[i] = 7'b0000000; a_chk[i] = 1'b0; d_chk[i] = 1'b0;
         a_val[i] = '0; d_val[i] = '0;
      end
      for (int r = 0; r < 2; r++) begin
         r_req[r] = 1'b0; r_we[r] = 1'b0; r_addr[r] = '0; r_wdata[r] = '0; drop[r] = 1'b0;
      end
      for (int c = 0; c < N; c++) begin
         for (int r = 0; r < 2; r++) begin
            if (drop[r]) begin
               r_req[r] = 1'b0;
               drop[r] = 1'b0;
            end else if (!r_req[r] && $urandom_range(0, 2) == 0) begin
               r_req[r] = 1'b1;
               r_we[r] = 1'($urandom);
               r_addr[r] = ($urandom_range(0, 3) == 0) ? 10'h3FE + 10'($urandom_range(0, 1)) : 10'($urandom);
               r_wdata[r] = 8'($urandom);
            end
         end
         in_req_0 = r_req[0]; in_we_0 = r_we[0]; in_addr_0 = r_addr[0]; in_wdata_0 = r_wdata[0];
         in_req_1 = r_req[1]; in_we_1 = r_we[1]; in_addr_1 = r_addr[1]; in_wdata_1 = r_wdata[1];
         mdat = 8'($urandom);
         in_mem_data = mdat;
         if (c == cap_at) exp_rd = mdat;
         if (c >= free_at && (r_req[0] || r_req[1])) begin
            g = (r_req[0] && r_req[1]) ? ~last_g : r_req[1];
            last_g = g;
            if (g && (r_addr[1] == 10'h3FE || r_addr[1] == 10'h3FF)) begin
               exp_v[c] = B_A1 | B_ERR | B_BSY;
               free_at = c + 2;
            end else begin
               exp_v[c] = B_AWE | B_BSY;
               a_chk[c] = 1'b1; a_val[c] = r_addr[g];
               exp_v[c+1] = (r_we[g] ? B_WR : B_RD) | B_BSY;
               a_chk[c+1] = 1'b1; a_val[c+1] = r_addr[g];
               if (r_we[g]) begin
                  d_chk[c+1] = 1'b1; d_val[c+1] = r_wdata[g];
               end
               exp_v[c+2] = (g ? B_A1 : B_A0) | B_BSY;
               if (!r_we[g]) cap_at = c + 2;
               free_at = c + 4;
            end
         end
         step();
         total++;
         if (obs !== exp_v[c]) begin
            bad++; $display("FAIL rnd_outs cyc=%0d got=%b exp=%b", c, obs, exp_v[c]);
         end
         total++;
         if (out_rdata !== exp_rd) begin
            bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, out_rdata, exp_rd);
         end
         if (a_chk[c]) begin
            total++;
            if (out_mem_addr !== a_val[c]) begin
               bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, out_mem_addr, a_val[c]);
            end
         end
         if (d_chk[c]) begin
            total++;
            if (out_mem_data !== d_val[c]) begin
               bad++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", c, out_mem_data, d_val[c]);
            end
         end
         if ((exp_v[c] & B_A0) != 7'b0000000) drop[0] = 1'b1;
         if ((exp_v[c] & B_A1) != 7'b0000000) drop[1] = 1'b1;
      end
      in_req_0 = 1'b0;
      in_req_1 = 1'b0;
      step();
      step();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_round_robin();
      test_refused();
      test_reset_mid();
      test_busy_ignore();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
